// File: rtl/input_buf_pkg.sv
// Shared definitions for the input buffer sequencer and the buffer datapath.
// Holds the sequencer state encoding and the default buffer geometry:
//   IB_DEPTH - register stages in the buffer chain (valid-pipe length)
//   IB_CNT_W - width of the tile length and vector counters
//   IB_NCH   - number of buffer channels
//   IB_N     - data width of one channel
package input_buf_pkg;

  localparam int IB_DEPTH = 3;
  localparam int IB_CNT_W = 8;
  localparam int IB_NCH   = 32;
  localparam int IB_N     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ib_state_t;

endpackage

// File: rtl/input_buf_ctrl.sv
// Sequencer for the multi-stage input buffer feeding the PE array.
// Drives the shared shift enable and the ping-pong bank select, handshakes
// with the prefetcher (in_valid/in_ready) and the PE array
// (out_valid/pe_ready), and tracks per-stage validity so bubbles and stalls
// never present stale data to the PEs.
//
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - asynchronous active-low reset
//   start      - one-cycle pulse, begins a tile when idle
//   abort      - synchronous abort, returns to idle and clears the valid pipe
//   tile_len   - vectors in the tile, latched on an accepted start
//   in_valid   - prefetcher presents a vector
//   in_ready   - vector accepted this cycle when in_valid is also high
//   pe_ready   - PE array consumes the last-stage vector this cycle
//   out_valid  - last buffer stage holds a valid vector
//   buf_en     - shift enable to all buffer stages
//   buf_select - active bank of the ping-pong buffer
//   busy       - high while loading or draining
//   done       - one-cycle pulse at tile completion
//   vec_cnt    - vectors delivered to the PEs in the current tile
module input_buf_ctrl
  import input_buf_pkg::*;
#(
  parameter int DEPTH = IB_DEPTH,
  parameter int CNT_W = IB_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] tile_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             pe_ready,
  output logic             out_valid,
  output logic             buf_en,
  output logic             buf_select,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_cnt
);

  ib_state_t        state;
  ib_state_t        state_next;
  logic [DEPTH-1:0] vld;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] len_last;
  logic             advance;
  logic             accept;
  logic             delivery;
  logic             last_accept;
  logic             last_delivery;
  logic             tile_start;

  // Handshake: the chain may shift whenever the last stage is empty or is
  // being consumed. in_ready follows pe_ready combinationally but never
  // in_valid, so the prefetcher sees no combinational loop.
  always_comb begin
    busy          = (state == LOAD) || (state == DRAIN);
    done          = (state == DONE);
    out_valid     = vld[DEPTH-1];
    advance       = busy && (!vld[DEPTH-1] || pe_ready);
    buf_en        = advance;
    in_ready      = (state == LOAD) && advance;
    accept        = in_valid && in_ready;
    delivery      = out_valid && pe_ready;
    len_last      = len_q - CNT_W'(1);
    last_accept   = accept && (in_cnt == len_last);
    last_delivery = delivery && (vec_cnt == len_last);
    tile_start    = (state == IDLE) && start && !abort && (tile_len != '0);
  end

  // Next-state logic. A zero-length tile goes straight to DONE so the
  // requester still gets its completion pulse. abort overrides everything.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = (tile_len != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        if (last_accept) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (last_delivery) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (abort) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Valid pipe mirrors the data chain: a bubble enters whenever the chain
  // shifts without an accepted vector, and everything holds on a stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
    end else if (abort) begin
      vld <= '0;
    end else if (advance) begin
      vld <= {vld[DEPTH-2:0], accept};
    end
  end

  // Counters are cleared only by a real tile start, so vec_cnt keeps the
  // final count of the last tile visible while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q   <= '0;
      in_cnt  <= '0;
      vec_cnt <= '0;
    end else if (tile_start) begin
      len_q   <= tile_len;
      in_cnt  <= '0;
      vec_cnt <= '0;
    end else if (!abort) begin
      if (accept) begin
        in_cnt <= in_cnt + CNT_W'(1);
      end
      if (delivery) begin
        vec_cnt <= vec_cnt + CNT_W'(1);
      end
    end
  end

  // The bank flips only when a tile actually drains to completion; aborted
  // and zero-length tiles leave the active bank untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_select <= 1'b0;
    end else if ((state == DRAIN) && last_delivery && !abort) begin
      buf_select <= ~buf_select;
    end
  end

endmodule
